// File: rtl/booth_multiplier_if.sv
// booth_multiplier_if
//   Operand/result bundle for the 16x16 signed Booth multiplier.
//
//   Handshake: valid-only, no ready. The producer raises in_valid for one
//   cycle per operand pair; the multiplier never stalls, so every pair sampled
//   with in_valid=1 comes back exactly one pipeline latency later with
//   out_valid=1, in issue order. product changes every cycle regardless of
//   valid; consumers must qualify it with out_valid.
//
//   Signals:
//     in_valid  - operand pair on x/y is valid this cycle
//     x         - multiplicand, signed two's complement
//     y         - multiplier, signed two's complement (Booth-recoded)
//     out_valid - product holds a valid result this cycle
//     product   - registered signed product x*y
//
//   Modports:
//     master - drives operands, observes results (the user of the multiplier)
//     slave  - the multiplier itself
interface booth_multiplier_if;
    logic        in_valid;
    logic [15:0] x;
    logic [15:0] y;
    logic        out_valid;
    logic [31:0] product;

    modport master (
        output in_valid,
        output x,
        output y,
        input  out_valid,
        input  product
    );

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        output out_valid,
        output product
    );
endinterface

// File: rtl/booth_multiplier.sv
// booth_multiplier
//   Pipelined 16x16 -> 32 signed multiplier. Radix-4 Booth recoding produces
//   eight partial products plus one row of negation-correction bits; a
//   Wallace tree of 3:2 compressors reduces the nine rows to a sum/carry pair,
//   and a single carry-propagate adder produces the product. All arithmetic
//   is modulo 2^32, which is exact for every 16x16 signed operand pair.
//
//   Ports:
//     clk   - single clock, rising edge
//     rst_n - asynchronous active-low reset; clears every pipeline register
//     bus   - booth_multiplier_if.slave (in_valid, x, y, out_valid, product)
//
//   Configuration macro:
//     BOOTH_MID_PIPE_EN - when defined, an extra register stage is placed
//                         after the tree reaches four rows (latency 3).
//                         When undefined the latency is 2. Results identical.
module booth_multiplier (
    input  logic              clk,
    input  logic              rst_n,
    booth_multiplier_if.slave bus
);

    localparam int NUM_PP = 8;

    // 3:2 compressor applied bitwise across whole rows; carry weighs one
    // column more, and the bit shifted out of column 31 is dropped (mod 2^32).
    function automatic logic [31:0] csa_sum(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] c);
        return a ^ b ^ c;
    endfunction

    function automatic logic [31:0] csa_carry(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    // ------------------------------------------------------------------
    // Booth recoding and partial-product generation
    // ------------------------------------------------------------------
    logic [16:0] y_ext;
    logic [31:0] x_ext;
    logic [31:0] x_dbl;
    logic [2:0]  trip;
    logic [31:0] mag;
    logic        neg;
    logic [31:0] pp [NUM_PP];
    logic [31:0] corr_row;

    always_comb begin
        y_ext    = {bus.y, 1'b0};              // implicit y[-1] = 0
        x_ext    = {{16{bus.x[15]}}, bus.x};
        x_dbl    = x_ext << 1;
        trip     = '0;
        mag      = '0;
        neg      = 1'b0;
        corr_row = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            trip = 3'(y_ext >> (2 * i));
            // Negative digits are 100/101/110; 111 is zero and needs nothing.
            neg  = trip[2] & ~(trip[1] & trip[0]);
            case (trip)
                3'b001, 3'b010, 3'b101, 3'b110: mag = x_ext;
                3'b011, 3'b100:                 mag = x_dbl;
                default:                        mag = '0;
            endcase
            // -m*4^i = (~m)*4^i + 4^i : complement the unshifted magnitude and
            // put the +1 into column 2i of the correction row.
            pp[i]    = (neg ? ~mag : mag) << (2 * i);
            corr_row = corr_row | (32'(neg) << (2 * i));
        end
    end

    // ------------------------------------------------------------------
    // Wallace tree, front half: 9 rows -> 6 rows -> 4 rows
    // ------------------------------------------------------------------
    logic [31:0] l1 [6];
    logic [31:0] l2 [4];

    always_comb begin
        l1[0] = csa_sum  (pp[0], pp[1], pp[2]);
        l1[1] = csa_carry(pp[0], pp[1], pp[2]);
        l1[2] = csa_sum  (pp[3], pp[4], pp[5]);
        l1[3] = csa_carry(pp[3], pp[4], pp[5]);
        l1[4] = csa_sum  (pp[6], pp[7], corr_row);
        l1[5] = csa_carry(pp[6], pp[7], corr_row);

        l2[0] = csa_sum  (l1[0], l1[1], l1[2]);
        l2[1] = csa_carry(l1[0], l1[1], l1[2]);
        l2[2] = csa_sum  (l1[3], l1[4], l1[5]);
        l2[3] = csa_carry(l1[3], l1[4], l1[5]);
    end

    // Rows and valid feeding the back half of the tree.
    logic [31:0] tail_rows [4];
    logic        tail_valid;

`ifdef BOOTH_MID_PIPE_EN
    logic [31:0] mid_rows_d [4];
    logic [31:0] mid_rows_q [4];
    logic        mid_valid_d;
    logic        mid_valid_q;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mid_rows_d[i] = l2[i];
        end
        mid_valid_d = bus.in_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mid_rows_q[i] <= '0;
            end
            mid_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mid_rows_q[i] <= mid_rows_d[i];
            end
            mid_valid_q <= mid_valid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tail_rows[i] = mid_rows_q[i];
        end
        tail_valid = mid_valid_q;
    end
`else
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            tail_rows[i] = l2[i];
        end
        tail_valid = bus.in_valid;
    end
`endif

    // ------------------------------------------------------------------
    // Wallace tree, back half: 4 rows -> 3 rows -> 2 rows, then register
    // ------------------------------------------------------------------
    logic [31:0] l3_sum;
    logic [31:0] l3_carry;
    logic [31:0] sum_row_d;
    logic [31:0] sum_row_q;
    logic [31:0] carry_row_d;
    logic [31:0] carry_row_q;
    logic        s1_valid_d;
    logic        s1_valid_q;

    always_comb begin
        l3_sum      = csa_sum  (tail_rows[0], tail_rows[1], tail_rows[2]);
        l3_carry    = csa_carry(tail_rows[0], tail_rows[1], tail_rows[2]);
        sum_row_d   = csa_sum  (l3_sum, l3_carry, tail_rows[3]);
        carry_row_d = csa_carry(l3_sum, l3_carry, tail_rows[3]);
        s1_valid_d  = tail_valid;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_row_q   <= '0;
            carry_row_q <= '0;
            s1_valid_q  <= 1'b0;
        end else begin
            sum_row_q   <= sum_row_d;
            carry_row_q <= carry_row_d;
            s1_valid_q  <= s1_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Final carry-propagate add; carry out of bit 31 is discarded
    // ------------------------------------------------------------------
    logic [31:0] product_d;
    logic [31:0] product_q;
    logic        out_valid_d;
    logic        out_valid_q;

    always_comb begin
        product_d   = sum_row_q + carry_row_q;
        out_valid_d = s1_valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            product_q   <= product_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.product   = product_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// tb_booth_multiplier
//   Self-checking bench for booth_multiplier. A monitor keeps a reference
//   model (plain signed multiply into an expected queue, plus a per-cycle
//   record of sampled in_valid) and compares out_valid and product on every
//   cycle. Directed cases pin the model with hand-computed literals.
module tb_booth_multiplier;

`ifdef BOOTH_MID_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    logic [31:0]        exp_q[$];   // expected products, issue order
    bit                 hist_v[$];  // sampled in_valid of the last LAT edges
    logic signed [31:0] sx;
    logic signed [31:0] sy;

    always @(posedge clk) begin
        if (!rst_n) begin
            hist_v.delete();
            for (int i = 0; i < LAT; i++) begin
                hist_v.push_back(1'b0);
            end
            exp_q.delete();
        end else begin
            if (bus.in_valid) begin
                sx = $signed(bus.x);
                sy = $signed(bus.y);
                exp_q.push_back(sx * sy);
            end
            hist_v.push_back(bus.in_valid);
            void'(hist_v.pop_front());
        end
        #1;
        if (!rst_n) begin
            check("reset out_valid", 32'(bus.out_valid), 32'd0);
            check("reset product", bus.product, 32'd0);
        end else begin
            check("out_valid timing", 32'(bus.out_valid), 32'(hist_v[0]));
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected result count", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("stream product", bus.product, exp_q.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    function automatic logic [15:0] pick16();
        logic [15:0] corners [4];
        corners[0] = 16'h8000;
        corners[1] = 16'h7FFF;
        corners[2] = 16'h0000;
        corners[3] = 16'hFFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
        return 16'($urandom);
    endfunction

    // One valid pair, then idle until its result is due and check it.
    task automatic directed(input logic [15:0] a, input logic [15:0] b,
                            input logic [31:0] lit, input string name);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = a;
        bus.y        = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x        = 16'($urandom);
        bus.y        = 16'($urandom);
        repeat (LAT - 1) @(negedge clk);
        check({name, " valid"}, 32'(bus.out_valid), 32'd1);
        check(name, bus.product, lit);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [15:0] cov_y   [4];
    logic [31:0] cov_pos [4];
    logic [31:0] cov_neg [4];
    int          stale;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cov_y[0] = 16'hAAAA; cov_pos[0] = 32'hFFFF_AAAA; cov_neg[0] = 32'h0000_5556;
        cov_y[1] = 16'h5555; cov_pos[1] = 32'h0000_5555; cov_neg[1] = 32'hFFFF_AAAB;
        cov_y[2] = 16'h6666; cov_pos[2] = 32'h0000_6666; cov_neg[2] = 32'hFFFF_999A;
        cov_y[3] = 16'hFFFF; cov_pos[3] = 32'hFFFF_FFFF; cov_neg[3] = 32'h0000_0001;

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.x        = '0;
        bus.y        = '0;

        // Reset held with random activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.x        = 16'($urandom);
            bus.y        = 16'($urandom);
        end
        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;

        // Directed cases with hand-computed results.
        directed(16'h0000, 16'h1234, 32'h0000_0000, "zero times value");
        directed(16'h8E9F, 16'hCC7C, 32'h16D0_C904, "two negatives");
        directed(16'h8000, 16'h8000, 32'h4000_0000, "min times min");
        directed(16'h8000, 16'h7FFF, 32'hC000_8000, "min times max");
        directed(16'h7FFF, 16'h7FFF, 32'h3FFF_0001, "max times max");
        for (int i = 0; i < 4; i++) begin
            directed(16'h0001, cov_y[i], cov_pos[i], "booth digits x=+1");
            directed(16'hFFFF, cov_y[i], cov_neg[i], "booth digits x=-1");
        end

        // Back-to-back pairs, then reset while they are still in the pipe.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = pick16();
        bus.y        = pick16();
        @(negedge clk);
        bus.x        = pick16();
        bus.y        = pick16();
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("async reset out_valid", 32'(bus.out_valid), 32'd0);
        check("async reset product", bus.product, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.x = 16'($urandom);
            bus.y = 16'($urandom);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            if (bus.out_valid) stale++;
        end
        check("no stale results after reset", 32'(stale), 32'd0);

        // Streaming: random valid pattern, random and corner operands.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.x        = pick16();
            bus.y        = pick16();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("all results drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
